// File: rtl/drone_pkg.sv
// -----------------------------------------------------------------------------
// drone_pkg
// Shared definitions for the attitude offset sequencer:
//   - axis codes presented to the shared per-axis offset generator
//   - sequencer FSM state encoding
//   - offset and accumulator widths
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package drone_pkg;

   localparam int OFFSET_W = 8;
   // 3 x 255 = 765 fits in 10 bits, so the accumulators never wrap.
   localparam int ACC_W    = 10;

   localparam logic [1:0] AXIS_ROLL  = 2'd0;
   localparam logic [1:0] AXIS_PITCH = 2'd1;
   localparam logic [1:0] AXIS_YAW   = 2'd2;
   localparam logic [1:0] AXIS_NONE  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ROLL,
      ST_PITCH,
      ST_YAW,
      ST_COMMIT
   } state_t;

endpackage

// File: rtl/link_watchdog.sv
// -----------------------------------------------------------------------------
// link_watchdog
// Counts cycles since the last accepted sample and flags link loss.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   kick        : accepted handshake this cycle; clears the counter
//   clear       : commit this cycle; drops the expired flag
//   expired     : registered link-lost flag
//   expire_now  : combinational, high in the cycle whose ending edge expires
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module link_watchdog #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic kick,
   input  logic clear,
   output logic expired,
   output logic expire_now
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expired_q, expired_d;

   // A kick on the would-be expiry edge wins: no expiry that cycle.
   assign expire_now = !kick && (cnt_q == LIMIT - CNT_W'(1));

   always_comb begin
      cnt_d     = cnt_q;
      expired_d = expired_q;
      if (kick) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      // Expired stays set (even across kicks) until a full sequence commits.
      if (clear) begin
         expired_d = 1'b0;
      end else if (expire_now) begin
         expired_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         expired_q <= expired_d;
      end
   end

   assign expired = expired_q;

endmodule

// File: rtl/attitude_offset_sequencer.sv
// -----------------------------------------------------------------------------
// attitude_offset_sequencer
// Time-multiplexes one external per-axis offset generator over roll, pitch and
// yaw, sums the three per-motor offset sets, saturates and commits all four
// motor offsets atomically. A link watchdog zeroes the offsets when samples
// stop arriving.
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   rx_valid / rx_ready            : sample handshake (ready only in IDLE)
//   roll/pitch/yaw_rec_val         : received attitude sample
//   gen_axis, gen_val              : request to the shared generator
//   gen_m1_off..gen_m4_off         : generator result for gen_axis/gen_val
//   motor_1_offset..motor_4_offset : committed, saturated offsets
//   offset_valid                   : one-cycle pulse on commit
//   link_lost                      : watchdog expired, offsets held at zero
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module attitude_offset_sequencer
   import drone_pkg::*;
#(
   parameter logic [OFFSET_W-1:0] OFFSET_MAX     = 8'd15,
   parameter int                  TIMEOUT_CYCLES = 1000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rx_valid,
   output logic                rx_ready,
   input  logic [OFFSET_W-1:0] roll_rec_val,
   input  logic [OFFSET_W-1:0] pitch_rec_val,
   input  logic [OFFSET_W-1:0] yaw_rec_val,
   output logic [1:0]          gen_axis,
   output logic [OFFSET_W-1:0] gen_val,
   input  logic [OFFSET_W-1:0] gen_m1_off,
   input  logic [OFFSET_W-1:0] gen_m2_off,
   input  logic [OFFSET_W-1:0] gen_m3_off,
   input  logic [OFFSET_W-1:0] gen_m4_off,
   output logic [OFFSET_W-1:0] motor_1_offset,
   output logic [OFFSET_W-1:0] motor_2_offset,
   output logic [OFFSET_W-1:0] motor_3_offset,
   output logic [OFFSET_W-1:0] motor_4_offset,
   output logic                offset_valid,
   output logic                link_lost
);

   function automatic logic [OFFSET_W-1:0] sat_offset(input logic [ACC_W-1:0] acc);
      if (acc > ACC_W'(OFFSET_MAX)) begin
         return OFFSET_MAX;
      end
      return acc[OFFSET_W-1:0];
   endfunction

   state_t              state_q, state_d;
   logic [OFFSET_W-1:0] roll_cap_q, roll_cap_d;
   logic [OFFSET_W-1:0] pitch_cap_q, pitch_cap_d;
   logic [OFFSET_W-1:0] yaw_cap_q, yaw_cap_d;
   logic [ACC_W-1:0]    acc_q [4];
   logic [ACC_W-1:0]    acc_d [4];
   logic [OFFSET_W-1:0] motor_q [4];
   logic [OFFSET_W-1:0] motor_d [4];
   logic [OFFSET_W-1:0] gen_off [4];
   logic [1:0]          gen_axis_q, gen_axis_d;
   logic [OFFSET_W-1:0] gen_val_q, gen_val_d;
   logic                rx_ready_q, rx_ready_d;
   logic                offset_valid_q, offset_valid_d;
   logic                handshake;
   logic                wd_expired;
   logic                wd_expire_now;

   assign gen_off[0] = gen_m1_off;
   assign gen_off[1] = gen_m2_off;
   assign gen_off[2] = gen_m3_off;
   assign gen_off[3] = gen_m4_off;

   assign handshake = rx_valid && (state_q == ST_IDLE);

   link_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_link_watchdog (
      .clk        (clk),
      .rst_n      (rst_n),
      .kick       (handshake),
      .clear      (state_q == ST_COMMIT),
      .expired    (wd_expired),
      .expire_now (wd_expire_now)
   );

   always_comb begin
      state_d        = state_q;
      roll_cap_d     = roll_cap_q;
      pitch_cap_d    = pitch_cap_q;
      yaw_cap_d      = yaw_cap_q;
      acc_d          = acc_q;
      motor_d        = motor_q;
      offset_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (handshake) begin
               roll_cap_d  = roll_rec_val;
               pitch_cap_d = pitch_rec_val;
               yaw_cap_d   = yaw_rec_val;
               for (int k = 0; k < 4; k++) acc_d[k] = '0;
               state_d = ST_ROLL;
            end
         end
         ST_ROLL, ST_PITCH, ST_YAW: begin
            for (int k = 0; k < 4; k++) acc_d[k] = acc_q[k] + ACC_W'(gen_off[k]);
            state_d = (state_q == ST_ROLL)  ? ST_PITCH :
                      (state_q == ST_PITCH) ? ST_YAW   : ST_COMMIT;
         end
         ST_COMMIT: begin
            for (int k = 0; k < 4; k++) motor_d[k] = sat_offset(acc_q[k]);
            offset_valid_d = 1'b1;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Expiry can only land in IDLE since a sequence restarts the counter.
      if (wd_expire_now) begin
         for (int k = 0; k < 4; k++) motor_d[k] = '0;
      end

      // Generator request is registered from the next state so it is stable
      // for the whole cycle the accumulators sample it.
      case (state_d)
         ST_ROLL:  begin gen_axis_d = AXIS_ROLL;  gen_val_d = roll_cap_d;  end
         ST_PITCH: begin gen_axis_d = AXIS_PITCH; gen_val_d = pitch_cap_d; end
         ST_YAW:   begin gen_axis_d = AXIS_YAW;   gen_val_d = yaw_cap_d;   end
         default:  begin gen_axis_d = AXIS_NONE;  gen_val_d = '0;          end
      endcase

      rx_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         roll_cap_q     <= '0;
         pitch_cap_q    <= '0;
         yaw_cap_q      <= '0;
         for (int k = 0; k < 4; k++) begin
            acc_q[k]   <= '0;
            motor_q[k] <= '0;
         end
         gen_axis_q     <= AXIS_NONE;
         gen_val_q      <= '0;
         rx_ready_q     <= 1'b1;
         offset_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         roll_cap_q     <= roll_cap_d;
         pitch_cap_q    <= pitch_cap_d;
         yaw_cap_q      <= yaw_cap_d;
         acc_q          <= acc_d;
         motor_q        <= motor_d;
         gen_axis_q     <= gen_axis_d;
         gen_val_q      <= gen_val_d;
         rx_ready_q     <= rx_ready_d;
         offset_valid_q <= offset_valid_d;
      end
   end

   assign rx_ready       = rx_ready_q;
   assign gen_axis       = gen_axis_q;
   assign gen_val        = gen_val_q;
   assign motor_1_offset = motor_q[0];
   assign motor_2_offset = motor_q[1];
   assign motor_3_offset = motor_q[2];
   assign motor_4_offset = motor_q[3];
   assign offset_valid   = offset_valid_q;
   assign link_lost      = wd_expired;

endmodule

// File: tb/tb_attitude_offset_sequencer.sv
`timescale 1ns/1ps
module tb_attitude_offset_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_valid = 1'b0;
   logic       rx_ready;
   logic [7:0] roll_v = '0, pitch_v = '0, yaw_v = '0;
   logic [1:0] gen_axis;
   logic [7:0] gen_val;
   logic [7:0] g1, g2, g3, g4;
   logic [7:0] m1, m2, m3, m4;
   logic       offset_valid, link_lost;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [7:0] m1, m2, m3, m4;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [7:0] r, p, y;
      logic [7:0] m1, m2, m3, m4;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   // Generator model: left/right table, same for every axis.
   function automatic logic [31:0] gen_model(input logic [7:0] v);
      if (v <= 8'd3)                  return {8'd0, 8'd6, 8'd0, 8'd6};
      if (v >= 8'd38 && v <= 8'd40)   return {8'd6, 8'd0, 8'd6, 8'd0};
      return 32'd0;
   endfunction
   assign {g1, g2, g3, g4} = gen_model(gen_val);

   attitude_offset_sequencer #(
      .OFFSET_MAX     (8'd15),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .roll_rec_val   (roll_v),
      .pitch_rec_val  (pitch_v),
      .yaw_rec_val    (yaw_v),
      .gen_axis       (gen_axis),
      .gen_val        (gen_val),
      .gen_m1_off     (g1),
      .gen_m2_off     (g2),
      .gen_m3_off     (g3),
      .gen_m4_off     (g4),
      .motor_1_offset (m1),
      .motor_2_offset (m2),
      .motor_3_offset (m3),
      .motor_4_offset (m4),
      .offset_valid   (offset_valid),
      .link_lost      (link_lost)
   );

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push_exp(input logic [7:0] a, b, c, d);
      exp_t e;
      e.m1 = a; e.m2 = b; e.m3 = c; e.m4 = d;
      exp_q.push_back(e);
   endtask

   // Returns at the negedge right after the accepting edge.
   task automatic accept(input logic [7:0] r, p, y);
      int w = 0;
      while (!rx_ready && w < 20) begin
         tick();
         w++;
      end
      chk("accept_ready", int'(rx_ready), 1);
      roll_v = r; pitch_v = p; yaw_v = y;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   // Scoreboard: every commit pulse pops one expected record.
   always @(negedge clk) begin
      if (rst_n && offset_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_offset_valid", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_m1", int'(m1), int'(e.m1));
            chk("sb_m2", int'(m2), int'(e.m2));
            chk("sb_m3", int'(m3), int'(e.m3));
            chk("sb_m4", int'(m4), int'(e.m4));
            chk("sb_link_lost", int'(link_lost), 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{8'd39,  8'd20,  8'd20,  8'd6,  8'd0,  8'd6,  8'd0};
      vecs[1] = '{8'd0,   8'd0,   8'd0,   8'd0,  8'd15, 8'd0,  8'd15};
      vecs[2] = '{8'd38,  8'd40,  8'd39,  8'd15, 8'd0,  8'd15, 8'd0};
      vecs[3] = '{8'd3,   8'd40,  8'd100, 8'd6,  8'd6,  8'd6,  8'd6};
      vecs[4] = '{8'd37,  8'd41,  8'd4,   8'd0,  8'd0,  8'd0,  8'd0};
      vecs[5] = '{8'd1,   8'd39,  8'd200, 8'd6,  8'd6,  8'd6,  8'd6};
      vecs[6] = '{8'd2,   8'd2,   8'd50,  8'd0,  8'd12, 8'd0,  8'd12};
      vecs[7] = '{8'd255, 8'd255, 8'd255, 8'd0,  8'd0,  8'd0,  8'd0};

      // Reset, then idle.
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      chk("rst_m1", int'(m1), 0);
      chk("rst_m2", int'(m2), 0);
      chk("rst_m3", int'(m3), 0);
      chk("rst_m4", int'(m4), 0);
      chk("rst_offset_valid", int'(offset_valid), 0);
      chk("rst_rx_ready", int'(rx_ready), 1);
      chk("rst_gen_axis", int'(gen_axis), 3);
      chk("rst_gen_val", int'(gen_val), 0);
      chk("rst_link_lost", int'(link_lost), 0);

      // Table-driven sequences; inputs scrambled and rx_valid held mid-sequence.
      for (int i = 0; i < 8; i++) begin
         push_exp(vecs[i].m1, vecs[i].m2, vecs[i].m3, vecs[i].m4);
         accept(vecs[i].r, vecs[i].p, vecs[i].y);
         chk("seq_axis_roll", int'(gen_axis), 0);
         chk("seq_val_roll", int'(gen_val), int'(vecs[i].r));
         chk("seq_rx_ready_busy", int'(rx_ready), 0);
         roll_v = ~vecs[i].r; pitch_v = ~vecs[i].p; yaw_v = ~vecs[i].y;
         rx_valid = 1'b1;
         tick();
         chk("seq_axis_pitch", int'(gen_axis), 1);
         chk("seq_val_pitch", int'(gen_val), int'(vecs[i].p));
         tick();
         chk("seq_axis_yaw", int'(gen_axis), 2);
         chk("seq_val_yaw", int'(gen_val), int'(vecs[i].y));
         tick();
         rx_valid = 1'b0;
         chk("seq_axis_commit", int'(gen_axis), 3);
         chk("seq_valid_early", int'(offset_valid), 0);
         tick();
         chk("seq_valid_pulse", int'(offset_valid), 1);
         chk("seq_rx_ready_idle", int'(rx_ready), 1);
         tick();
         chk("seq_valid_low", int'(offset_valid), 0);
      end

      // rx_valid held high: one acceptance every 5 cycles.
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      rx_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chk("cont_rx_ready", int'(rx_ready), (i % 5 == 0) ? 1 : 0);
         if (rx_ready) begin
            roll_v = 8'd39; pitch_v = 8'd20; yaw_v = 8'd20;
            push_exp(8'd6, 8'd0, 8'd6, 8'd0);
         end else begin
            roll_v = 8'd0; pitch_v = 8'd0; yaw_v = 8'd0;
         end
         tick();
      end
      rx_valid = 1'b0;
      repeat (2) tick();

      // Watchdog expiry after a commit, then recovery.
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      push_exp(8'd6, 8'd0, 8'd6, 8'd0);
      accept(8'd39, 8'd20, 8'd20);
      repeat (15) tick();
      chk("wd_before_link_lost", int'(link_lost), 0);
      chk("wd_before_m1", int'(m1), 6);
      tick();
      chk("wd_expire_link_lost", int'(link_lost), 1);
      chk("wd_expire_m1", int'(m1), 0);
      chk("wd_expire_m3", int'(m3), 0);
      chk("wd_expire_no_valid", int'(offset_valid), 0);
      push_exp(8'd0, 8'd15, 8'd0, 8'd15);
      accept(8'd0, 8'd0, 8'd0);
      chk("wd_lost_in_seq", int'(link_lost), 1);
      repeat (3) tick();
      chk("wd_lost_before_commit", int'(link_lost), 1);
      tick();
      chk("wd_recovered", int'(link_lost), 0);
      chk("wd_recovered_m2", int'(m2), 15);

      // Reset during PITCH abandons the sequence.
      accept(8'd39, 8'd20, 8'd20);
      tick();
      chk("rmid_in_pitch", int'(gen_axis), 1);
      rst_n = 1'b0;
      tick();
      chk("rmid_rx_ready", int'(rx_ready), 1);
      chk("rmid_gen_axis", int'(gen_axis), 3);
      chk("rmid_gen_val", int'(gen_val), 0);
      chk("rmid_m2", int'(m2), 0);
      chk("rmid_m4", int'(m4), 0);
      chk("rmid_valid", int'(offset_valid), 0);
      chk("rmid_link_lost", int'(link_lost), 0);
      tick();
      rst_n = 1'b1;
      repeat (6) tick();
      chk("rmid_no_commit_m1", int'(m1), 0);

      // Handshake on the expiry edge wins; counter restarts from it.
      push_exp(8'd6, 8'd0, 8'd6, 8'd0);
      accept(8'd39, 8'd20, 8'd20);
      repeat (15) tick();
      push_exp(8'd0, 8'd15, 8'd0, 8'd15);
      roll_v = 8'd0; pitch_v = 8'd0; yaw_v = 8'd0;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      chk("race_link_lost", int'(link_lost), 0);
      chk("race_accepted", int'(gen_axis), 0);
      repeat (15) tick();
      chk("race_restart_no_lost", int'(link_lost), 0);
      chk("race_m2", int'(m2), 15);
      tick();
      chk("race_restart_expire", int'(link_lost), 1);

      chk("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
